// File: rtl/mux2_rr_arbiter.sv
// Two-input round-robin arbiter driving a shared data mux, with a per-grant
// burst limit so that neither requester can starve the other.
module mux2_rr_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_a,
    input  logic [WIDTH-1:0] data_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] data_b,
    input  logic             out_ready,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic             sel,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             ack_a,
    output logic             ack_b
);

    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);
    localparam logic SERVED_A = 1'b1;
    localparam logic SERVED_B = 1'b0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_served_q, last_served_d;

    logic cur_is_a;
    logic cur_req;
    logic oth_req;
    logic beat;
    logic grant_end;

    assign gnt_a     = (state_q == GRANT_A);
    assign gnt_b     = (state_q == GRANT_B);
    assign sel       = (state_q == GRANT_A);
    assign out_data  = sel ? data_a : data_b;
    assign out_valid = (gnt_a & req_a) | (gnt_b & req_b);
    assign ack_a     = gnt_a & req_a & out_ready;
    assign ack_b     = gnt_b & req_b & out_ready;

    assign cur_is_a  = (state_q == GRANT_A);
    assign cur_req   = cur_is_a ? req_a : req_b;
    assign oth_req   = cur_is_a ? req_b : req_a;
    assign beat      = ack_a | ack_b;
    assign grant_end = !cur_req || (beat && (cnt_q == LAST_BEAT));

    // A stalled downstream freezes the whole grant, including a requester
    // that has dropped its request, so nothing moves until out_ready returns.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        last_served_d = last_served_q;
        case (state_q)
            IDLE: begin
                if (req_a && (!req_b || (last_served_q == SERVED_B))) begin
                    state_d = GRANT_A;
                    cnt_d   = '0;
                end else if (req_b) begin
                    state_d = GRANT_B;
                    cnt_d   = '0;
                end
            end
            GRANT_A, GRANT_B: begin
                if (out_ready) begin
                    if (grant_end) begin
                        last_served_d = cur_is_a ? SERVED_A : SERVED_B;
                        cnt_d         = '0;
                        if (oth_req) begin
                            state_d = cur_is_a ? GRANT_B : GRANT_A;
                        end else if (cur_req) begin
                            state_d = state_q;
                        end else begin
                            state_d = IDLE;
                        end
                    end else if (beat) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Reset points last_served at B so the first contended grant goes to A.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            last_served_q <= SERVED_B;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            last_served_q <= last_served_d;
        end
    end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Directed bench for mux2_rr_arbiter: a vector table for steady-state behaviour
// plus hand-written sequences for stalls, async reset and MAX_BURST=1.
module tb_mux2_rr_arbiter;

    logic       clk;
    logic       rst;
    logic       req_a;
    logic       req_b;
    logic [7:0] data_a;
    logic [7:0] data_b;
    logic       out_ready;

    logic       gnt_a, gnt_b, sel, out_valid, ack_a, ack_b;
    logic [7:0] out_data;
    logic       gnt_a1, gnt_b1, sel1, out_valid1, ack_a1, ack_b1;
    logic [7:0] out_data1;

    int checks = 0;
    int errors = 0;

    // Flag order: {gnt_a, gnt_b, sel, out_valid, ack_a, ack_b}
    localparam logic [5:0] F_IDLE    = 6'b000000;
    localparam logic [5:0] F_A_BEAT  = 6'b101110;
    localparam logic [5:0] F_B_BEAT  = 6'b010101;
    localparam logic [5:0] F_A_NOREQ = 6'b101000;
    localparam logic [5:0] F_A_STALL = 6'b101100;

    typedef struct {
        logic       rst;
        logic       req_a;
        logic       req_b;
        logic       rdy;
        logic [7:0] da;
        logic [7:0] db;
        logic [5:0] exp_flags;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[$];

    mux2_rr_arbiter #(.WIDTH(8), .MAX_BURST(4)) dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .data_a(data_a), .req_b(req_b), .data_b(data_b),
        .out_ready(out_ready),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .sel(sel), .out_valid(out_valid),
        .out_data(out_data), .ack_a(ack_a), .ack_b(ack_b)
    );

    mux2_rr_arbiter #(.WIDTH(8), .MAX_BURST(1)) dut1 (
        .clk(clk), .rst(rst),
        .req_a(req_a), .data_a(data_a), .req_b(req_b), .data_b(data_b),
        .out_ready(out_ready),
        .gnt_a(gnt_a1), .gnt_b(gnt_b1), .sel(sel1), .out_valid(out_valid1),
        .out_data(out_data1), .ack_a(ack_a1), .ack_b(ack_b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void addVec(input logic r, input logic ra, input logic rb,
                                   input logic rdy, input logic [7:0] da,
                                   input logic [7:0] db, input logic [5:0] f,
                                   input logic [7:0] d);
        vec_t v;
        v.rst = r; v.req_a = ra; v.req_b = rb; v.rdy = rdy;
        v.da = da; v.db = db; v.exp_flags = f; v.exp_data = d;
        vecs.push_back(v);
    endfunction

    task automatic applyStimulus(input logic r, input logic ra, input logic rb,
                                 input logic [7:0] da, input logic [7:0] db,
                                 input logic rdy);
        @(negedge clk);
        rst = r; req_a = ra; req_b = rb; data_a = da; data_b = db; out_ready = rdy;
        #1;
    endtask

    task automatic checkValue(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput(input string name, input bit use_b1,
                               input logic [5:0] f, input logic [7:0] d);
        logic [13:0] act;
        if (use_b1)
            act = {gnt_a1, gnt_b1, sel1, out_valid1, ack_a1, ack_b1, out_data1};
        else
            act = {gnt_a, gnt_b, sel, out_valid, ack_a, ack_b, out_data};
        checkValue(name, 32'(act), 32'({f, d}));
        if (gnt_a && gnt_b) checkValue({name, "_excl"}, 32'(1), 32'(0));
    endtask

    initial begin
        rst = 1'b1; req_a = 1'b0; req_b = 1'b0;
        data_a = 8'h00; data_b = 8'h00; out_ready = 1'b0;

        // Single requester A: continuous beats, burst wraps without dropping gnt_a.
        addVec(1, 1, 0, 1, 8'h11, 8'h22, F_IDLE, 8'h22);
        addVec(0, 1, 0, 1, 8'h11, 8'h22, F_IDLE, 8'h22);
        for (int i = 0; i < 9; i++) addVec(0, 1, 0, 1, 8'h11, 8'h22, F_A_BEAT, 8'h11);
        // Contention: 4 beats A, 4 beats B, 4 beats A.
        addVec(1, 1, 1, 1, 8'hA5, 8'h5A, F_IDLE, 8'h5A);
        addVec(0, 1, 1, 1, 8'hA5, 8'h5A, F_IDLE, 8'h5A);
        for (int i = 0; i < 4; i++) addVec(0, 1, 1, 1, 8'hA5, 8'h5A, F_A_BEAT, 8'hA5);
        for (int i = 0; i < 4; i++) addVec(0, 1, 1, 1, 8'hA5, 8'h5A, F_B_BEAT, 8'h5A);
        for (int i = 0; i < 4; i++) addVec(0, 1, 1, 1, 8'hA5, 8'h5A, F_A_BEAT, 8'hA5);
        // Early release: A drops after 2 beats, B takes over next cycle.
        addVec(1, 1, 1, 1, 8'h11, 8'h22, F_IDLE, 8'h22);
        addVec(0, 1, 1, 1, 8'h11, 8'h22, F_IDLE, 8'h22);
        addVec(0, 1, 1, 1, 8'h11, 8'h22, F_A_BEAT, 8'h11);
        addVec(0, 1, 1, 1, 8'h11, 8'h22, F_A_BEAT, 8'h11);
        addVec(0, 0, 1, 1, 8'h11, 8'h22, F_A_NOREQ, 8'h11);
        addVec(0, 0, 1, 1, 8'h11, 8'h22, F_B_BEAT, 8'h22);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].req_a, vecs[i].req_b,
                          vecs[i].da, vecs[i].db, vecs[i].rdy);
            checkOutput($sformatf("vec%0d", i), 1'b0, vecs[i].exp_flags, vecs[i].exp_data);
        end
        checkValue("early_release_last_served_A", 32'(dut.last_served_q), 32'(1));

        // Backpressure: stall 3 cycles after beat 2, grant still needs 4 acked beats.
        applyStimulus(1, 1, 1, 8'h11, 8'h22, 1);
        applyStimulus(0, 1, 1, 8'h11, 8'h22, 1);
        checkOutput("bp_idle", 1'b0, F_IDLE, 8'h22);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(0, 1, 1, 8'h11, 8'h22, 1);
            checkOutput($sformatf("bp_beat%0d", i + 1), 1'b0, F_A_BEAT, 8'h11);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 1, 8'h11, 8'h22, 0);
            checkOutput($sformatf("bp_stall%0d", i), 1'b0, F_A_STALL, 8'h11);
            checkValue($sformatf("bp_stall_cnt%0d", i), 32'(dut.cnt_q), 32'(2));
        end
        for (int i = 2; i < 4; i++) begin
            applyStimulus(0, 1, 1, 8'h11, 8'h22, 1);
            checkOutput($sformatf("bp_beat%0d", i + 1), 1'b0, F_A_BEAT, 8'h11);
        end
        applyStimulus(0, 1, 1, 8'h11, 8'h22, 1);
        checkOutput("bp_handover_b", 1'b0, F_B_BEAT, 8'h22);
        applyStimulus(0, 1, 1, 8'h11, 8'h22, 1);
        checkOutput("bp_b_beat2", 1'b0, F_B_BEAT, 8'h22);

        // Async reset mid-burst of B; after release A must win despite last_served=A before.
        @(posedge clk);
        #3 rst = 1'b1;
        #1 checkOutput("async_rst_immediate", 1'b0, F_IDLE, 8'h22);
        applyStimulus(0, 1, 1, 8'h11, 8'h22, 1);
        checkOutput("async_rst_released_idle", 1'b0, F_IDLE, 8'h22);
        applyStimulus(0, 1, 1, 8'h11, 8'h22, 1);
        checkOutput("async_rst_first_grant_A", 1'b0, F_A_BEAT, 8'h11);

        // MAX_BURST=1: strict alternation on every beat.
        applyStimulus(1, 1, 1, 8'h33, 8'h44, 1);
        applyStimulus(0, 1, 1, 8'h33, 8'h44, 1);
        checkOutput("mb1_idle", 1'b1, F_IDLE, 8'h44);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, 1, 1, 8'h33, 8'h44, 1);
            if (i % 2 == 0)
                checkOutput($sformatf("mb1_beat%0d_A", i), 1'b1, F_A_BEAT, 8'h33);
            else
                checkOutput($sformatf("mb1_beat%0d_B", i), 1'b1, F_B_BEAT, 8'h44);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
